// File: rtl/spi_ram_responder.sv
// Serial SRAM responder (23LC1024-style, sequential mode) for the nanoV SPI link.
// Runs on the CPU clock; one SPI bit is taken per cycle with spi_select low and spi_clk_en high.
module spi_ram_responder #(
    parameter int          ADDR_BITS  = 10,
    parameter              INIT_FILE  = "",
    parameter logic [7:0]  RDSR_VALUE = 8'h40
) (
    input  logic       clk12MHz,
    input  logic       rstn,
    input  logic       spi_select,
    input  logic       spi_clk_en,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       active,
    output logic       wr_strobe,
    output logic [2:0] dbg_state_o
);

    localparam logic [2:0] ST_CMD    = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_RDATA  = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_STATUS = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [7:0]           mem [2**ADDR_BITS];

    logic [2:0]           state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           tx_q, tx_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 wr_mode_q, wr_mode_d;
    logic                 miso_q, miso_d;
    logic                 strobe_q, strobe_d;
    logic                 mem_we;

    logic [7:0]           byte_in;
    logic [ADDR_BITS-1:0] addr_shift;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [7:0]           rd_byte_shift;
    logic [7:0]           rd_byte_inc;

    // Shifting the address straight into an ADDR_BITS-wide register drops the upper address bits.
    assign byte_in       = {shift_q[6:0], spi_mosi};
    assign addr_shift    = {addr_q[ADDR_BITS-2:0], spi_mosi};
    assign addr_inc      = addr_q + ADDR_ONE;
    assign rd_byte_shift = mem[addr_shift];
    assign rd_byte_inc   = mem[addr_inc];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_mode_d = wr_mode_q;
        miso_d    = miso_q;
        strobe_d  = 1'b0;
        mem_we    = 1'b0;

        if (spi_select) begin
            state_d = ST_CMD;
            cnt_d   = 5'd0;
            shift_d = 8'h00;
            miso_d  = 1'b0;
        end else if (spi_clk_en) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 5'd1;
            case (state_q)
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        case (byte_in)
                            8'h03, 8'h02: begin
                                state_d   = ST_ADDR;
                                wr_mode_d = (byte_in == 8'h02);
                            end
                            8'h05: begin
                                state_d = ST_STATUS;
                                miso_d  = RDSR_VALUE[7];
                                tx_d    = {RDSR_VALUE[6:0], 1'b0};
                            end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    addr_d = addr_shift;
                    if (cnt_q == 5'd23) begin
                        cnt_d = 5'd0;
                        if (wr_mode_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            // First read bit goes out on the same edge: zero dummy cycles.
                            state_d = ST_RDATA;
                            miso_d  = rd_byte_shift[7];
                            tx_d    = {rd_byte_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == 5'd7) begin
                        cnt_d  = 5'd0;
                        addr_d = addr_inc;
                        miso_d = rd_byte_inc[7];
                        tx_d   = {rd_byte_inc[6:0], 1'b0};
                    end else begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                ST_WDATA: begin
                    miso_d = 1'b0;
                    if (cnt_q == 5'd7) begin
                        cnt_d    = 5'd0;
                        mem_we   = 1'b1;
                        strobe_d = 1'b1;
                        addr_d   = addr_inc;
                    end
                end
                ST_STATUS: begin
                    if (cnt_q == 5'd7) begin
                        cnt_d  = 5'd0;
                        miso_d = RDSR_VALUE[7];
                        tx_d   = {RDSR_VALUE[6:0], 1'b0};
                    end else begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                default: begin
                    cnt_d  = cnt_q;
                    miso_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk12MHz or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_CMD;
            cnt_q     <= 5'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            wr_mode_q <= 1'b0;
            miso_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_mode_q <= wr_mode_d;
            miso_q    <= miso_d;
            strobe_q  <= strobe_d;
        end
    end

    // Memory has no reset; contents survive rstn.
    always_ff @(posedge clk12MHz) begin
        if (mem_we && rstn) mem[addr_q] <= byte_in;
    end

    assign spi_miso    = miso_q;
    assign wr_strobe   = strobe_q;
    assign active      = (state_q != ST_CMD) && (state_q != ST_IGNORE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: writes, reads, wrap, status, unknown command,
// partial write, clk_en gaps and asynchronous reset mid-read.
module tb_spi_ram_responder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       spi_select;
    logic       spi_clk_en;
    logic       spi_mosi;
    logic       spi_miso;
    logic       active;
    logic       wr_strobe;
    logic [2:0] dbg_state;

    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;

    spi_ram_responder #(.ADDR_BITS(10), .INIT_FILE(""), .RDSR_VALUE(8'h40)) dut (
        .clk12MHz    (clk),
        .rstn        (rstn),
        .spi_select  (spi_select),
        .spi_clk_en  (spi_clk_en),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .active      (active),
        .wr_strobe   (wr_strobe),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe === 1'b1) wr_cnt++;

    // Each call presents one bit; the following posedge takes it. miso is what the host sees for it.
    task automatic spi_bit(input logic mosi, input int maxgap, output logic miso);
        int gap;
        gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
        repeat (gap) begin
            @(negedge clk);
            spi_clk_en = 1'b0;
        end
        @(negedge clk);
        spi_clk_en = 1'b1;
        spi_mosi   = mosi;
        miso       = spi_miso;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input int maxgap, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], maxgap, m);
            rx[i] = m;
        end
    endtask

    task automatic begin_txn();
        @(negedge clk);
        spi_clk_en = 1'b0;
        spi_select = 1'b0;
    endtask

    task automatic end_txn();
        @(negedge clk);
        spi_clk_en = 1'b0;
        spi_select = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr, input int maxgap,
                            output logic [7:0] rx_or);
        logic [7:0] rx;
        rx_or = 8'h00;
        xfer_byte(cmd, maxgap, rx);         rx_or |= rx;
        xfer_byte(addr[23:16], maxgap, rx); rx_or |= rx;
        xfer_byte(addr[15:8], maxgap, rx);  rx_or |= rx;
        xfer_byte(addr[7:0], maxgap, rx);   rx_or |= rx;
    endtask

    task automatic test_reset();
        rstn = 1'b0; spi_select = 1'b1; spi_clk_en = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b expected 0", active); end
        total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [7:0] rx, rx_or;
        int c0;
        c0 = wr_cnt;
        begin_txn();
        send_hdr(8'h02, 24'h000010, 0, rx_or);
        xfer_byte(8'hA5, 0, rx); rx_or |= rx;
        xfer_byte(8'h3C, 0, rx); rx_or |= rx;
        end_txn();
        total++; if (rx_or !== 8'h00) begin bad++; $display("FAIL wr_miso_zero: got %h expected 00", rx_or); end
        total++; if (wr_cnt - c0 !== 2) begin bad++; $display("FAIL wr_strobe_count: got %0d expected 2", wr_cnt - c0); end
        begin_txn();
        send_hdr(8'h03, 24'h000010, 0, rx_or);
        total++; if (rx_or !== 8'h00) begin bad++; $display("FAIL rd_hdr_miso_zero: got %h expected 00", rx_or); end
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'hA5) begin bad++; $display("FAIL rd_byte0: got %h expected a5", rx); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL rd_active: got %b expected 1", active); end
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h3C) begin bad++; $display("FAIL rd_byte1: got %h expected 3c", rx); end
        end_txn();
        total++; if (wr_cnt - c0 !== 2) begin bad++; $display("FAIL rd_no_strobe: got %0d expected 2", wr_cnt - c0); end
    endtask

    task automatic test_wrap();
        logic [7:0] rx, rx_or;
        begin_txn();
        send_hdr(8'h02, 24'h0003FF, 0, rx_or);
        xfer_byte(8'h11, 0, rx);
        xfer_byte(8'h22, 0, rx);
        end_txn();
        begin_txn();
        send_hdr(8'h03, 24'h0003FF, 0, rx_or);
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h11) begin bad++; $display("FAIL wrap_rd0: got %h expected 11", rx); end
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h22) begin bad++; $display("FAIL wrap_rd1: got %h expected 22", rx); end
        end_txn();
        begin_txn();
        send_hdr(8'h03, 24'hFFFFFF, 0, rx_or);
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h11) begin bad++; $display("FAIL addr_mask: got %h expected 11", rx); end
        end_txn();
    endtask

    task automatic test_status();
        logic [7:0] rx;
        begin_txn();
        xfer_byte(8'h05, 0, rx);
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h40) begin bad++; $display("FAIL status0: got %h expected 40", rx); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL status_active0: got %b expected 1", active); end
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h40) begin bad++; $display("FAIL status1: got %h expected 40", rx); end
        @(negedge clk);
        spi_clk_en = 1'b0;
        spi_select = 1'b1;
        total++; if (active !== 1'b1) begin bad++; $display("FAIL status_active_pre_desel: got %b expected 1", active); end
        @(negedge clk);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL status_active_post_desel: got %b expected 0", active); end
    endtask

    task automatic test_ignore();
        logic [7:0] rx, rx_or;
        int c0;
        c0 = wr_cnt;
        rx_or = 8'h00;
        begin_txn();
        xfer_byte(8'h9F, 0, rx);
        for (int i = 0; i < 4; i++) begin
            xfer_byte(8'hFF, 0, rx);
            rx_or |= rx;
        end
        total++; if (rx_or !== 8'h00) begin bad++; $display("FAIL ignore_miso: got %h expected 00", rx_or); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL ignore_active: got %b expected 0", active); end
        end_txn();
        total++; if (wr_cnt !== c0) begin bad++; $display("FAIL ignore_strobe: got %0d expected %0d", wr_cnt, c0); end
        begin_txn();
        send_hdr(8'h03, 24'h000010, 0, rx_or);
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'hA5) begin bad++; $display("FAIL ignore_mem: got %h expected a5", rx); end
        end_txn();
    endtask

    task automatic test_partial_write();
        logic [7:0] rx, rx_or;
        logic m;
        int c0;
        begin_txn();
        send_hdr(8'h02, 24'h000020, 0, rx_or);
        xfer_byte(8'h5A, 0, rx);
        end_txn();
        c0 = wr_cnt;
        begin_txn();
        send_hdr(8'h02, 24'h000020, 0, rx_or);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 0, m);
        end_txn();
        total++; if (wr_cnt !== c0) begin bad++; $display("FAIL partial_strobe: got %0d expected %0d", wr_cnt, c0); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL partial_state: got %0d expected 0", dbg_state); end
        begin_txn();
        send_hdr(8'h03, 24'h000020, 0, rx_or);
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'h5A) begin bad++; $display("FAIL partial_mem: got %h expected 5a", rx); end
        end_txn();
    endtask

    task automatic test_gaps_and_reset();
        logic [7:0] rx, rx_or;
        logic [7:0] exp_bytes [4];
        logic m;
        exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hAD; exp_bytes[2] = 8'hBE; exp_bytes[3] = 8'hEF;
        begin_txn();
        send_hdr(8'h02, 24'h000100, 0, rx_or);
        for (int i = 0; i < 4; i++) xfer_byte(exp_bytes[i], 0, rx);
        end_txn();
        for (int pass = 0; pass < 2; pass++) begin
            begin_txn();
            send_hdr(8'h03, 24'h000100, pass * 3, rx_or);
            for (int i = 0; i < 4; i++) begin
                xfer_byte(8'h00, pass * 3, rx);
                total++;
                if (rx !== exp_bytes[i]) begin
                    bad++;
                    $display("FAIL gap_read pass%0d byte%0d: got %h expected %h", pass, i, rx, exp_bytes[i]);
                end
            end
            end_txn();
        end
        begin_txn();
        send_hdr(8'h03, 24'h000100, 0, rx_or);
        xfer_byte(8'h00, 0, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, 0, m);
        @(negedge clk);
        total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL pre_reset_miso: got %b expected 1", spi_miso); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL pre_reset_active: got %b expected 1", active); end
        spi_clk_en = 1'b0;
        rstn = 1'b0;
        #1;
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL async_reset_miso: got %b expected 0", spi_miso); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL async_reset_active: got %b expected 0", active); end
        @(negedge clk);
        rstn = 1'b1;
        send_hdr(8'h03, 24'h000100, 0, rx_or);
        xfer_byte(8'h00, 0, rx);
        total++; if (rx !== 8'hDE) begin bad++; $display("FAIL post_reset_read: got %h expected de", rx); end
        end_txn();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_status();
        test_ignore();
        test_partial_write();
        test_gaps_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
